// File: rtl/bit_placement_8x16_seq_if.sv
// ---------------------------------------------------------------------------
// bit_placement_8x16_seq_if
// Fragment-in / word-out bundle for bit_placement_8x16_seq.
//
// Upstream fragment side:
//   i_valid, i_data_bus[DATA_WIDTH/2], i_cmd[COMMAND_WIDTH], i_last, i_en
//   o_ready   : block can take a fragment
// Downstream word side:
//   o_valid, o_data_bus[DATA_WIDTH], o_mask[DATA_WIDTH], o_overlap
//   i_ready   : downstream takes the word
//
// modport slave  : the placement block
// modport master : the environment driving fragments and consuming words
// ---------------------------------------------------------------------------
interface bit_placement_8x16_seq_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1
);
    logic                    i_valid;
    logic [DATA_WIDTH/2-1:0] i_data_bus;
    logic [COMMAND_WIDTH-1:0] i_cmd;
    logic                    i_last;
    logic                    i_en;
    logic                    o_ready;
    logic                    o_valid;
    logic [DATA_WIDTH-1:0]   o_data_bus;
    logic [DATA_WIDTH-1:0]   o_mask;
    logic                    i_ready;
    logic                    o_overlap;

    modport slave (
        input  i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
        output o_ready, o_valid, o_data_bus, o_mask, o_overlap
    );

    modport master (
        output i_valid, i_data_bus, i_cmd, i_last, i_en, i_ready,
        input  o_ready, o_valid, o_data_bus, o_mask, o_overlap
    );
endinterface

// File: rtl/bit_placement_8x16_seq.sv
// ---------------------------------------------------------------------------
// bit_placement_8x16_seq
// Sequential inverse of the 16->8 contiguous bit selector. Each accepted
// 8-bit fragment is written into a 16-bit window at bit offset cmd+1; when
// the fragment flagged last is accepted the assembled word and the mask of
// written bits are presented until the downstream handshake.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bit_placement_8x16_seq_if.slave (fragment in, word out)
//
// Build option:
//   BIT_PLACEMENT_OVERLAP_CHECK_EN - when defined, o_overlap is a sticky flag
//   set by any fragment landing on already-written bits and cleared on the
//   word handshake. When undefined, o_overlap is tied low and no detection
//   logic exists. Data behaviour is the same in both builds.
//
// Only DATA_WIDTH=16 / COMMAND_WIDTH=3 is supported.
// ---------------------------------------------------------------------------
module bit_placement_8x16_seq #(
    parameter int DATA_WIDTH    = 16,
    parameter int COMMAND_WIDTH = $clog2(DATA_WIDTH) - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bit_placement_8x16_seq_if.slave      bus
);
    localparam int HALF_WIDTH = DATA_WIDTH / 2;
    localparam int OFF_WIDTH  = COMMAND_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q,   acc_d;
    logic [DATA_WIDTH-1:0] mask_q,  mask_d;

    logic                  hold;
    logic                  accept;
    logic [OFF_WIDTH-1:0]  off;

    assign hold   = (state_q == ST_HOLD);
    // Ready depends on state only, so downstream i_ready never reaches o_ready.
    assign accept = bus.i_valid & bus.i_en & ~hold;
    // Offset range is 1..8; the extra bit keeps cmd=7 from wrapping.
    assign off    = OFF_WIDTH'(bus.i_cmd) + OFF_WIDTH'(1);

`ifdef BIT_PLACEMENT_OVERLAP_CHECK_EN
    logic overlap_q, overlap_d;
    logic overlap_hit;

    // Any previously written bit under the incoming window counts as overlap.
    assign overlap_hit = |mask_q[off +: HALF_WIDTH];

    always_comb begin
        overlap_d = overlap_q;
        if (hold) begin
            if (bus.i_ready) begin
                overlap_d = 1'b0;
            end
        end else if (accept && overlap_hit) begin
            overlap_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlap_q <= 1'b0;
        end else begin
            overlap_q <= overlap_d;
        end
    end

    assign bus.o_overlap = overlap_q;
`else
    assign bus.o_overlap = 1'b0;
`endif

    // Next-state and accumulation; later fragments overwrite earlier bits.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d[off +: HALF_WIDTH]  = bus.i_data_bus;
                    mask_d[off +: HALF_WIDTH] = '1;
                    state_d = bus.i_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    mask_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                mask_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.o_ready = ~hold;
    assign bus.o_valid = hold;

    // Word and mask read as zero whenever no word is being presented.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
            assign bus.o_data_bus[gi] = acc_q[gi]  & hold;
            assign bus.o_mask[gi]     = mask_q[gi] & hold;
        end
    endgenerate

endmodule

// File: tb/tb_bit_placement_8x16_seq.sv
module tb_bit_placement_8x16_seq;

    logic clk;
    logic rst_n;

    bit_placement_8x16_seq_if bus ();

    bit_placement_8x16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] m;
        logic        o;
    } word_t;

    word_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word under construction and whether one is presented.
    logic [15:0] m_data;
    logic [15:0] m_mask;
    logic        m_ovl;
    logic        m_hold;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic ovl_expect(input logic o);
`ifdef BIT_PLACEMENT_OVERLAP_CHECK_EN
        return o;
`else
        return 1'b0 & o;
`endif
    endfunction

    task automatic model_clear();
        m_data = '0;
        m_mask = '0;
        m_ovl  = 1'b0;
        m_hold = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic cycle(input logic v, input logic en, input logic [2:0] cmd,
                         input logic [7:0] data, input logic last, input logic rdy);
        logic        acc_ok;
        int          off;
        logic [15:0] win;
        bus.i_valid    = v;
        bus.i_en       = en;
        bus.i_cmd      = cmd;
        bus.i_data_bus = data;
        bus.i_last     = last;
        bus.i_ready    = rdy;
        acc_ok = v & en & ~m_hold;
        @(negedge clk);
        chk("o_ready", {31'd0, bus.o_ready}, {31'd0, ~m_hold});
        chk("o_valid", {31'd0, bus.o_valid}, {31'd0, m_hold});
        if (!m_hold)
            chk("idle_outputs_zero", {bus.o_data_bus, bus.o_mask}, 32'd0);
        @(posedge clk);
        if (m_hold) begin
            if (rdy) model_clear();
        end else if (acc_ok) begin
            off = int'(cmd) + 1;
            win = 16'h00FF << off;
            if ((m_mask & win) != 16'd0) m_ovl = 1'b1;
            m_data = (m_data & ~win) | ({8'd0, data} << off);
            m_mask = m_mask | win;
            if (last) begin
                sb_q.push_back('{d: m_data, m: m_mask, o: ovl_expect(m_ovl)});
                m_hold = 1'b1;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("async_rst_o_ready", {31'd0, bus.o_ready}, 32'd1);
        sb_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every presented word against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_word", {16'd0, bus.o_data_bus}, 32'hFFFF_FFFF);
            end else begin
                chk("word_data",    {16'd0, bus.o_data_bus}, {16'd0, sb_q[0].d});
                chk("word_mask",    {16'd0, bus.o_mask},     {16'd0, sb_q[0].m});
                chk("word_overlap", {31'd0, bus.o_overlap},  {31'd0, sb_q[0].o});
                if (bus.i_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_en       = 1'b0;
        bus.i_cmd      = '0;
        bus.i_data_bus = '0;
        bus.i_last     = 1'b0;
        bus.i_ready    = 1'b0;
        model_clear();
        #3;
        chk("rst_o_valid",   {31'd0, bus.o_valid},   32'd0);
        chk("rst_o_ready",   {31'd0, bus.o_ready},   32'd1);
        chk("rst_o_data",    {16'd0, bus.o_data_bus}, 32'd0);
        chk("rst_o_mask",    {16'd0, bus.o_mask},    32'd0);
        chk("rst_o_overlap", {31'd0, bus.o_overlap}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single fragment, offset 1
        cycle(1, 1, 3'd0, 8'hA5, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Single fragment, offset 8
        cycle(1, 1, 3'd7, 8'hFF, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Two fragments at the window extremes
        cycle(1, 1, 3'd0, 8'h0F, 0, 1);
        cycle(1, 1, 3'd7, 8'hF0, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Overlapping fragments
        cycle(1, 1, 3'd3, 8'hFF, 0, 1);
        cycle(1, 1, 3'd4, 8'h00, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Backpressure: hold three cycles with an i_valid pulse that must be dropped
        cycle(1, 1, 3'd2, 8'h3C, 1, 0);
        cycle(0, 1, 3'd0, 8'h00, 0, 0);
        cycle(1, 1, 3'd5, 8'hFF, 1, 0);
        cycle(0, 1, 3'd0, 8'h00, 0, 0);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Enable low: fragment ignored, then a real word
        cycle(1, 0, 3'd1, 8'hFF, 1, 1);
        cycle(1, 0, 3'd6, 8'hAA, 0, 1);
        cycle(1, 1, 3'd2, 8'h81, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);
        // Reset during ACCUM discards the partial word
        cycle(1, 1, 3'd5, 8'hEE, 0, 1);
        mid_reset();
        cycle(1, 1, 3'd1, 8'h01, 1, 1);
        cycle(0, 1, 3'd0, 8'h00, 0, 1);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 800; i++) begin
            if (i % 250 == 249) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0,
                      $urandom_range(0, 4) != 0,
                      3'($urandom_range(0, 7)),
                      8'($urandom_range(0, 255)),
                      $urandom_range(0, 2) == 0,
                      $urandom_range(0, 1) == 1);
            end
        end

        // Drain any word still presented
        for (int i = 0; i < 4 && m_hold; i++) begin
            cycle(0, 1, 3'd0, 8'h00, 0, 1);
        end
        chk("drain_done", {31'd0, m_hold}, 32'd0);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
